// File: rtl/dmem_responder_if.sv
// Data-bus request/response signals between the memory-stage initiator and the responder.
// Initiator drives req_* and rsp_ready; responder drives req_ready and rsp_*.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word RAM responder: one request in flight; response after WAIT_CYCLES wait states plus EXEC.
// The response is held until rsp_ready; no request is accepted outside IDLE.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0]   r_mem [DEPTH];

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_fault;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic          w_accept;
  logic          w_fault;

  assign w_accept = bus.req_valid && r_req_ready;
  // Any address bit above the index range means the word lies beyond DEPTH.
  assign w_fault  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:AW+2] != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_fault     <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_idx       <= bus.req_addr[AW+1:2];
            r_wdata     <= bus.req_wdata;
            r_be        <= bus.req_be;
            r_fault     <= w_fault;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_EXEC;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_EXEC;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_fault;
          r_rsp_rdata <= (r_fault || r_we) ? 32'd0 : r_mem[r_idx];
          r_state     <= S_RESP;
        end
        default: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Storage is never reset; a reset clears r_state so a pending store never reaches EXEC.
  always_ff @(posedge clk) begin
    if (r_state == S_EXEC && r_we && !r_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_CYCLES=2 / DEPTH=1024 instance for the vector table and corner cases,
// plus a WAIT_CYCLES=0 / DEPTH=16 instance for back-to-back throughput.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if a_if ();
  dmem_responder_if b_if ();

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_a (.clk(clk), .reset(rst_n), .bus(a_if));
  dmem_responder #(.DEPTH(16),   .WAIT_CYCLES(0)) u_b (.clk(clk), .reset(rst_n), .bus(b_if));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction on instance A with rsp_ready high throughout.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                     input string name);
    int   lat;
    logic rdy_low;
    logic got;
    @(negedge clk);
    chk({name, "_idle_rdy"}, {31'd0, a_if.req_ready}, 32'd1);
    a_if.req_valid = 1'b1;
    a_if.req_we    = we;
    a_if.req_addr  = addr;
    a_if.req_wdata = wdata;
    a_if.req_be    = be;
    a_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (a_if.rsp_valid) begin
        got = 1'b1;
      end else begin
        if (a_if.req_ready) rdy_low = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: rsp_valid never rose, required within 40 cycles", name);
    end else begin
      chk({name, "_rdata"}, a_if.rsp_rdata, exp_rd);
      chk({name, "_err"}, {31'd0, a_if.rsp_err}, {31'd0, exp_err});
      chk({name, "_latency"}, lat, 32'd4);
      chk({name, "_busy_rdy_low"}, {31'd0, rdy_low}, 32'd1);
      @(posedge clk); #1;
      chk({name, "_ret_rdy"}, {31'd0, a_if.req_ready}, 32'd1);
      chk({name, "_ret_vld"}, {31'd0, a_if.rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    logic        stable_ok;
    logic        got;
    logic        seen_vld;
    logic        rdy_s;
    int          cyc;
    int          acc_n;
    int          rsp_n;
    int          last_rsp;
    int          acc_at [5];
    logic        b_we   [5];
    logic [31:0] b_addr [5];
    logic [31:0] b_wd   [5];
    logic [31:0] b_exp  [5];
    logic        b_err  [5];

    vecs[0]  = '{1'b1, 32'h10,     32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,     32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,     32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,     32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,     32'h0,        4'hF, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0,      32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h13,     32'h0,        4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'h1000,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h2,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'hFFFFFFFC, 32'h0,      4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h0,      32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 32'h24,     32'h0BADCAFE, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h24,     32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h24,     32'h0,        4'hF, 32'h0BADCAFE, 1'b0};
    vecs[14] = '{1'b1, 32'h40,     32'h01234567, 4'hF, 32'h0,        1'b0};

    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = 32'd0;
    a_if.req_wdata = 32'd0; a_if.req_be = 4'd0; a_if.rsp_ready = 1'b0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = 32'd0;
    b_if.req_wdata = 32'd0; b_if.req_be = 4'd0; b_if.rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", {31'd0, a_if.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, a_if.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", a_if.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, a_if.rsp_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Backpressure: load held in RESP for 10 cycles while another request is offered.
    @(negedge clk);
    a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_addr = 32'h10; a_if.req_be = 4'hF;
    a_if.rsp_ready = 1'b0;
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (a_if.rsp_valid) got = 1'b1;
    end
    chk("bp_rsp_arrives", {31'd0, got}, 32'd1);
    stable_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_if.req_valid = 1'b1; a_if.req_we = 1'b1; a_if.req_addr = 32'h10;
      a_if.req_wdata = 32'h0; a_if.req_be = 4'hF;
      if (a_if.rsp_valid !== 1'b1 || a_if.rsp_rdata !== 32'hDEADBEEF ||
          a_if.rsp_err !== 1'b0 || a_if.req_ready !== 1'b0) stable_ok = 1'b0;
    end
    chk("bp_hold_stable", {31'd0, stable_ok}, 32'd1);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    a_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_vld",   {31'd0, a_if.rsp_valid}, 32'd0);
    chk("bp_rel_rdy",   {31'd0, a_if.req_ready}, 32'd1);
    chk("bp_rel_rdata", a_if.rsp_rdata, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, "bp_no_store");

    // Reset while a store to 0x40 sits in WAIT.
    @(negedge clk);
    a_if.req_valid = 1'b1; a_if.req_we = 1'b1; a_if.req_addr = 32'h40;
    a_if.req_wdata = 32'h5A5A5A5A; a_if.req_be = 4'hF; a_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_in_wait_rdy", {31'd0, a_if.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy",   {31'd0, a_if.req_ready}, 32'd1);
    chk("mid_rst_vld",   {31'd0, a_if.rsp_valid}, 32'd0);
    chk("mid_rst_rdata", a_if.rsp_rdata, 32'd0);
    chk("mid_rst_err",   {31'd0, a_if.rsp_err}, 32'd0);
    seen_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (a_if.rsp_valid) seen_vld = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (a_if.rsp_valid) seen_vld = 1'b1;
    end
    chk("mid_no_response", {31'd0, seen_vld}, 32'd0);
    txn(1'b0, 32'h40, 32'h0, 4'hF, 32'h01234567, 1'b0, "mid_mem_kept");

    // Instance B (no wait states): requests held back-to-back, rsp_ready high.
    b_we[0] = 1'b1; b_addr[0] = 32'h4;  b_wd[0] = 32'h0000BEEF; b_exp[0] = 32'h0;        b_err[0] = 1'b0;
    b_we[1] = 1'b1; b_addr[1] = 32'h8;  b_wd[1] = 32'h12345678; b_exp[1] = 32'h0;        b_err[1] = 1'b0;
    b_we[2] = 1'b0; b_addr[2] = 32'h4;  b_wd[2] = 32'h0;        b_exp[2] = 32'h0000BEEF; b_err[2] = 1'b0;
    b_we[3] = 1'b0; b_addr[3] = 32'h8;  b_wd[3] = 32'h0;        b_exp[3] = 32'h12345678; b_err[3] = 1'b0;
    b_we[4] = 1'b0; b_addr[4] = 32'h40; b_wd[4] = 32'h0;        b_exp[4] = 32'h0;        b_err[4] = 1'b1;

    @(negedge clk);
    b_if.req_valid = 1'b1; b_if.req_be = 4'hF; b_if.rsp_ready = 1'b1;
    b_if.req_we = b_we[0]; b_if.req_addr = b_addr[0]; b_if.req_wdata = b_wd[0];
    cyc = 0; acc_n = 0; rsp_n = 0; last_rsp = 0;
    for (int c = 0; c < 60 && rsp_n < 5; c++) begin
      @(negedge clk);
      rdy_s = b_if.req_ready;
      @(posedge clk);
      cyc++;
      if (rdy_s && b_if.req_valid && acc_n < 5) begin
        acc_at[acc_n] = cyc;
        acc_n++;
        #1;
        if (acc_n < 5) begin
          b_if.req_we = b_we[acc_n]; b_if.req_addr = b_addr[acc_n]; b_if.req_wdata = b_wd[acc_n];
        end else begin
          b_if.req_valid = 1'b0;
        end
      end else begin
        #1;
      end
      if (b_if.rsp_valid && rsp_n < acc_n) begin
        chk($sformatf("b%0d_rdata", rsp_n), b_if.rsp_rdata, b_exp[rsp_n]);
        chk($sformatf("b%0d_err", rsp_n), {31'd0, b_if.rsp_err}, {31'd0, b_err[rsp_n]});
        chk($sformatf("b%0d_latency", rsp_n), cyc - acc_at[rsp_n] + 1, 32'd2);
        if (rsp_n > 0) chk($sformatf("b%0d_interval", rsp_n), cyc - last_rsp, 32'd3);
        last_rsp = cyc;
        rsp_n++;
      end
    end
    if (rsp_n < 5) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b_timeout: got %0d responses, expected 5", rsp_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
